// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  bhw;
        logic        write_notread;
    } bus_req_t;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/mem_bus_req_slot.sv
// One-deep pending request register for a single bus master, with a sticky
// overflow error for strobes that cannot be accepted.
module mem_bus_req_slot
    import mem_bus_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_ni,
    input  logic     req_dv_i,
    input  bus_req_t req_i,
    input  logic     block_i,   // this master owns the in-flight transaction
    input  logic     take_i,    // arbiter grants this master this cycle
    output logic     valid_o,
    output bus_req_t req_o,
    output logic     err_o
);

    logic     valid_q, valid_d;
    logic     err_q, err_d;
    bus_req_t req_q, req_d;

    // A grant empties the slot; a strobe loads it unless consumed by bypass or rejected.
    always_comb begin
        valid_d = valid_q;
        req_d   = req_q;
        err_d   = err_q | (req_dv_i & (valid_q | block_i));
        if (take_i) begin
            valid_d = 1'b0;
        end else if (req_dv_i && !valid_q && !block_i) begin
            valid_d = 1'b1;
            req_d   = req_i;
        end
    end

    // Slot registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    assign valid_o = valid_q;
    assign req_o   = req_q;
    assign err_o   = err_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master, single-outstanding arbiter in front of memory_top.
//
// state | meaning
// IDLE  | nothing in flight; arbitrate pending slots plus same-cycle strobes
// WAIT  | one request issued; wait for i_mem_DV or the timeout to expire
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_m0_data,
    input  logic [31:0] i_m0_address,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    input  logic        i_m0_DV,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    input  logic [31:0] i_m1_data,
    input  logic [31:0] i_m1_address,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    input  logic        i_m1_DV,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic [31:0] o_mem_data,
    output logic [31:0] o_mem_address,
    output logic [2:0]  o_mem_bhw,
    output logic        o_mem_write_notread,
    output logic        o_mem_DV,
    input  logic [31:0] i_mem_data,
    input  logic        i_mem_DV,
    output logic        o_grant,
    output logic        o_busy,
    output logic        o_timeout,
    output logic [1:0]  o_err
);

    localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          last_q, grant_q, busy_q, timeout_q, mem_dv_q;
    logic [1:0]    rsp_dv_q;
    logic [31:0]   m0_data_q, m1_data_q;
    bus_req_t      mem_req_q;

    bus_req_t      in_req   [2];
    bus_req_t      slot_req [2];
    logic [1:0]    req_dv, pend, take, block, slot_err, cand;
    logic          gsel;
    bus_req_t      sel_req;

    assign in_req[M_CPU] = '{address: i_m0_address, data: i_m0_data,
                             bhw: i_m0_bhw, write_notread: i_m0_write_notread};
    assign in_req[M_AUX] = '{address: i_m1_address, data: i_m1_data,
                             bhw: i_m1_bhw, write_notread: i_m1_write_notread};
    assign req_dv        = {i_m1_DV, i_m0_DV};

    // Arbitration: contention goes to the master that lost the previous contention.
    always_comb begin
        cand    = pend | req_dv;
        gsel    = (cand == 2'b11) ? ~last_q : cand[1];
        sel_req = pend[gsel] ? slot_req[gsel] : in_req[gsel];
        take    = 2'b00;
        if (state_q == IDLE && cand != 2'b00) take[gsel] = 1'b1;
        block   = 2'b00;
        if (state_q == WAIT) block[grant_q] = 1'b1;
    end

    for (genvar n = 0; n < 2; n++) begin : g_slot
        mem_bus_req_slot u_slot (
            .clk_i    (i_clk),
            .rst_ni   (i_reset_n),
            .req_dv_i (req_dv[n]),
            .req_i    (in_req[n]),
            .block_i  (block[n]),
            .take_i   (take[n]),
            .valid_o  (pend[n]),
            .req_o    (slot_req[n]),
            .err_o    (slot_err[n])
        );
    end

    // Transaction FSM with registered memory-side and response-side outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            grant_q   <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            mem_dv_q  <= 1'b0;
            rsp_dv_q  <= 2'b00;
            m0_data_q <= '0;
            m1_data_q <= '0;
            mem_req_q <= '0;
        end else begin
            mem_dv_q  <= 1'b0;
            rsp_dv_q  <= 2'b00;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cand != 2'b00) begin
                        mem_req_q <= sel_req;
                        mem_dv_q  <= 1'b1;
                        grant_q   <= gsel;
                        if (cand == 2'b11) last_q <= gsel;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != CNT_LAST) cnt_q <= cnt_q + CNT_ONE;
                    if (i_mem_DV || cnt_q == CNT_LAST) begin
                        if (grant_q) m1_data_q <= i_mem_DV ? i_mem_data : ERR_DATA;
                        else         m0_data_q <= i_mem_DV ? i_mem_data : ERR_DATA;
                        rsp_dv_q[grant_q] <= 1'b1;
                        timeout_q <= ~i_mem_DV;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_mem_address       = mem_req_q.address;
    assign o_mem_data          = mem_req_q.data;
    assign o_mem_bhw           = mem_req_q.bhw;
    assign o_mem_write_notread = mem_req_q.write_notread;
    assign o_mem_DV            = mem_dv_q;
    assign o_m0_data           = m0_data_q;
    assign o_m1_data           = m1_data_q;
    assign o_m0_DV             = rsp_dv_q[0];
    assign o_m1_DV             = rsp_dv_q[1];
    assign o_grant             = grant_q;
    assign o_busy              = busy_q;
    assign o_timeout           = timeout_q;
    assign o_err               = slot_err;

endmodule
